// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I/RV64I opcode, field and instruction-format types shared by the decode stage
package riscv_pkg;
   localparam int REG_W = 5;
   typedef enum logic [6:0] {
      OPC_LOAD      = 7'h03,
      OPC_MISC_MEM  = 7'h0F,
      OPC_OP_IMM    = 7'h13,
      OPC_AUIPC     = 7'h17,
      OPC_OP_IMM_32 = 7'h1B,
      OPC_STORE     = 7'h23,
      OPC_OP        = 7'h33,
      OPC_LUI       = 7'h37,
      OPC_OP_32     = 7'h3B,
      OPC_BRANCH    = 7'h63,
      OPC_JALR      = 7'h67,
      OPC_JAL       = 7'h6F,
      OPC_SYSTEM    = 7'h73
   } opcode_t;
   typedef logic [2:0] funct3_t;
   typedef logic [6:0] funct7_t;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_t;
   typedef struct packed {
      funct7_t funct7; logic [REG_W-1:0] rs2; logic [REG_W-1:0] rs1;
      funct3_t funct3; logic [REG_W-1:0] rd; logic [6:0] opcode;
   } r_type_t;
   typedef struct packed {
      logic [11:0] imm; logic [REG_W-1:0] rs1; funct3_t funct3; logic [REG_W-1:0] rd; logic [6:0] opcode;
   } i_type_t;
   typedef struct packed {
      logic [6:0] imm_hi; logic [REG_W-1:0] rs2; logic [REG_W-1:0] rs1;
      funct3_t funct3; logic [4:0] imm_lo; logic [6:0] opcode;
   } s_type_t;
   typedef struct packed {
      logic imm12; logic [5:0] imm10_5; logic [REG_W-1:0] rs2; logic [REG_W-1:0] rs1;
      funct3_t funct3; logic [3:0] imm4_1; logic imm11; logic [6:0] opcode;
   } sb_type_t;
   typedef struct packed {
      logic [19:0] imm; logic [REG_W-1:0] rd; logic [6:0] opcode;
   } u_type_t;
   typedef struct packed {
      logic imm20; logic [9:0] imm10_1; logic imm11; logic [7:0] imm19_12;
      logic [REG_W-1:0] rd; logic [6:0] opcode;
   } uj_type_t;
   typedef union packed {
      r_type_t r; i_type_t i; s_type_t s; sb_type_t sb; u_type_t u; uj_type_t uj;
   } instr_t;
   function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
      return op inside {OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR, OPC_SYSTEM} ? IMM_I :
             op == OPC_STORE  ? IMM_S :
             op == OPC_BRANCH ? IMM_B :
             op inside {OPC_LUI, OPC_AUIPC} ? IMM_U :
             op == OPC_JAL    ? IMM_J : IMM_NONE;
   endfunction
   // The *_32 word opcodes only exist in the 64-bit base set
   function automatic logic is_legal(input logic [6:0] op, input logic rv64);
      return op inside {OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
                        OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM} ||
             (rv64 && op inside {OPC_OP_IMM_32, OPC_OP_32});
   endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate builder for the I/S/B/U/J formats, sign-extended from bit 31
module imm_gen import riscv_pkg::*; #(
   parameter int XLEN = 32
) (
   input  instr_t            ir_i,
   input  imm_fmt_t          fmt_i,
   output logic [XLEN-1:0]   imm_o
);
   logic [31:0] imm32;
   logic        unused_op;
   assign unused_op = ^ir_i.r.opcode;
   always_comb begin
      imm32 = fmt_i == IMM_I ? {{20{ir_i.i.imm[11]}}, ir_i.i.imm} :
              fmt_i == IMM_S ? {{20{ir_i.s.imm_hi[6]}}, ir_i.s.imm_hi, ir_i.s.imm_lo} :
              fmt_i == IMM_B ? {{20{ir_i.sb.imm12}}, ir_i.sb.imm11, ir_i.sb.imm10_5, ir_i.sb.imm4_1, 1'b0} :
              fmt_i == IMM_U ? {ir_i.u.imm, 12'b0} :
              fmt_i == IMM_J ? {{12{ir_i.uj.imm20}}, ir_i.uj.imm19_12, ir_i.uj.imm11, ir_i.uj.imm10_1, 1'b0} :
              32'b0;
   end
   assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage with prioritised operand bypass and load-use interlock.
// Define ID_BYPASS_EN to forward from the bypass channels; otherwise any match interlocks.
module id_stage import riscv_pkg::*; #(
   parameter int XLEN = 32,
   parameter int NBYP = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [31:0]           in_ir,
   input  logic                  flush,
   output logic [REG_W-1:0]      rf_raddr1,
   output logic [REG_W-1:0]      rf_raddr2,
   input  logic [XLEN-1:0]       rf_rdata1,
   input  logic [XLEN-1:0]       rf_rdata2,
   input  logic [NBYP-1:0]       byp_valid,
   input  logic [NBYP-1:0]       byp_busy,
   input  logic [NBYP*REG_W-1:0] byp_rd,
   input  logic [NBYP*XLEN-1:0]  byp_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [6:0]            out_opcode,
   output logic [2:0]            out_funct3,
   output logic [6:0]            out_funct7,
   output logic [REG_W-1:0]      out_rd,
   output logic [XLEN-1:0]       out_rs1,
   output logic [XLEN-1:0]       out_rs2,
   output logic [XLEN-1:0]       out_imm,
   output logic                  out_illegal
);
   instr_t            ir;
   logic [REG_W-1:0]  rs1, rs2;
   logic [NBYP-1:0]   m1, m2;
   logic [XLEN-1:0]   fw1, fw2, op1, op2, imm_c;
   logic              bz1, bz2, hazard, load, valid_d;
   logic              valid_q, ill_q;
   logic [XLEN-1:0]   pc_q, rs1_q, rs2_q, imm_q;
   logic [6:0]        opcode_q, funct7_q;
   logic [2:0]        funct3_q;
   logic [REG_W-1:0]  rd_q;
   assign ir        = in_ir;
   assign rs1       = ir.r.rs1;
   assign rs2       = ir.r.rs2;
   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;
   genvar g;
   for (g = 0; g < NBYP; g++) begin : g_match
      assign m1[g] = byp_valid[g] && byp_rd[g*REG_W +: REG_W] == rs1;
      assign m2[g] = byp_valid[g] && byp_rd[g*REG_W +: REG_W] == rs2;
   end
`ifdef ID_BYPASS_EN
   // Walk oldest to youngest so the lowest-index match wins
   always_comb begin
      fw1 = rf_rdata1;
      fw2 = rf_rdata2;
      bz1 = 1'b0;
      bz2 = 1'b0;
      for (int i = NBYP-1; i >= 0; i--) begin
         if (m1[i]) begin fw1 = byp_data[i*XLEN +: XLEN]; bz1 = byp_busy[i]; end
         if (m2[i]) begin fw2 = byp_data[i*XLEN +: XLEN]; bz2 = byp_busy[i]; end
      end
   end
`else
   logic unused_byp;
   assign unused_byp = ^{byp_data, byp_busy};
   assign fw1 = rf_rdata1;
   assign fw2 = rf_rdata2;
   assign bz1 = |m1;
   assign bz2 = |m2;
`endif
   assign op1      = rs1 == '0 ? '0 : fw1;
   assign op2      = rs2 == '0 ? '0 : fw2;
   assign hazard   = in_valid && ((rs1 != '0 && bz1) || (rs2 != '0 && bz2));
   assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
   assign load     = in_valid && in_ready;
   assign valid_d  = flush ? 1'b0 : load ? 1'b1 : out_ready ? 1'b0 : valid_q;
   imm_gen #(.XLEN(XLEN)) u_imm (.ir_i(ir), .fmt_i(imm_fmt(ir.r.opcode)), .imm_o(imm_c));
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q  <= 1'b0;
         ill_q    <= 1'b0;
         pc_q     <= '0;
         opcode_q <= '0;
         funct3_q <= '0;
         funct7_q <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
      end else begin
         valid_q <= valid_d;
         if (load) begin
            ill_q    <= !is_legal(ir.r.opcode, XLEN == 64);
            pc_q     <= in_pc;
            opcode_q <= ir.r.opcode;
            funct3_q <= ir.r.funct3;
            funct7_q <= ir.r.funct7;
            rd_q     <= ir.r.rd;
            rs1_q    <= op1;
            rs2_q    <= op2;
            imm_q    <= imm_c;
         end
      end
   end
   assign out_valid   = valid_q;
   assign out_illegal = ill_q;
   assign out_pc      = pc_q;
   assign out_opcode  = opcode_q;
   assign out_funct3  = funct3_q;
   assign out_funct7  = funct7_q;
   assign out_rd      = rd_q;
   assign out_rs1     = rs1_q;
   assign out_rs2     = rs2_q;
   assign out_imm     = imm_q;
endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode pipeline stage between fetch and execute. Each cycle it accepts one instruction word and PC over a valid/ready handshake and extracts opcode, funct3, funct7 and register indices. It generates the sign-extended immediate for all five formats, reads operands from an external register file, and resolves them through N prioritised bypass channels. A load-use interlock stalls the stage when a matching bypass producer is not ready. Results are registered into the decode/execute pipeline register.

## Interface
- XLEN, 32, datapath and immediate width (32 or 64)
- NBYP, 3, number of bypass channels; channel 0 is youngest and has highest priority
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  PC of the instruction
- in_ir  in  32  instruction word
- flush  in  1  kill the instruction being accepted and the registered instruction
- rf_raddr1, rf_raddr2  out  5 each  register-file read addresses, equal to in_ir[19:15] and in_ir[24:20]
- rf_rdata1, rf_rdata2  in  XLEN each  combinational register-file read data
- byp_valid  in  NBYP  channel holds a register write
- byp_busy  in  NBYP  channel result not yet available (load in flight)
- byp_rd  in  NBYP×5  destination register per channel
- byp_data  in  NBYP×XLEN  result per channel
- out_valid  out  1  pipeline register holds a valid instruction
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  registered PC
- out_opcode, out_funct3, out_funct7  out  7/3/7  registered fields
- out_rd  out  5  destination register
- out_rs1, out_rs2  out  XLEN each  resolved operands
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  opcode not in RV32I/RV64I base set

## Operation
- Immediate format is chosen from the opcode: I for OP-IMM, LOAD, JALR and SYSTEM; S for STORE; B for BRANCH; U for LUI and AUIPC; J for JAL. R-type produces an immediate of 0.
- The immediate is always sign-extended from instruction bit 31 to XLEN.
- Operand resolution for each of rs1 and rs2:
  - An index of 0 yields 0.
  - Otherwise the lowest-index channel with byp_valid set and byp_rd equal to the index supplies byp_data.
  - If no channel matches, the operand is rf_rdata.
- Hazard: the matching channel chosen above has byp_busy set, for either rs1 or rs2 of a valid incoming instruction.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Load: on in_valid && in_ready, all out_* fields are registered and out_valid is set to 1.
- Drain: when out_valid && out_ready and no load occurs, out_valid is cleared to 0.
- Hazard with space in the register: a bubble is inserted (out_valid set to 0) and in_ir is held by fetch.
- Stall: while out_valid && !out_ready, every out_* signal holds stable.
- Flush: out_valid is set to 0 on the next edge and the input is not accepted. Flush overrides load, drain and hazard.
- out_illegal is registered alongside the other fields and does not block issue.

## Timing
- Latency is 1 cycle from acceptance to out_valid.
- Throughput is 1 instruction per cycle with no hazard.
- The path from in_ir through bypass match to in_ready is combinational in the same cycle.
- rf read is combinational in the same cycle.
- Reset (asynchronous, resetn=0):
  - out_valid = 0 and out_illegal = 0.
  - All data outputs are 0.
  - Reset asserted mid-stall discards the held instruction.
- Simultaneous drain and load: the new instruction replaces the old one with no bubble.

## Configuration
- With ID_BYPASS_EN defined, bypassing operates as described above.
- Without it, operands always come from rf_rdata (or 0 for x0), and byp_data is ignored.
- In that case any byp_valid channel whose byp_rd matches a nonzero source index is treated as a hazard regardless of byp_busy. The result is a full interlock.

## Structure
- The riscv package holds:
  - opcode_t enum, funct3_t, funct7_t and the instruction-format unions (r/i/s/sb/u/uj).
  - imm_fmt_t enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
  - The register-index width constant.
- Sub-module imm_gen is purely combinational. It takes ir and imm_fmt_t and produces the XLEN-wide immediate.
- Bypass selection is a generate loop over NBYP inside id_stage.

## Test plan
- addi x1,x0,5 (0x00500093), in_valid=1, out_ready=1 -> next cycle out_valid=1, out_opcode=0x13, out_rd=1, out_imm=5, out_rs1=0.
- sw x2,-4(x1) (0xFE20AE23) -> out_imm=0xFFFFFFFC, out_opcode=0x23, out_funct3=2.
- add x3,x1,x2 (0x002081B3) with rf_rdata=0xAA, ch0 rd=1 data 0x11, ch1 rd=1 data 0x33, ch2 rd=2 data 0x22 -> out_rs1=0x11, out_rs2=0x22. Without ID_BYPASS_EN: in_ready=0 and no issue.
- Same add with ch0 rd=1 byp_busy=1 for 2 cycles -> in_ready=0 for both cycles and out_valid=0 bubble. When busy clears, the instruction issues the following cycle with ch0 data.
- out_ready=0 for 3 cycles after a load -> outputs stable, in_ready=0. Then out_ready=1 together with a new valid input -> back-to-back issue with no bubble.
- flush=1 in the same cycle as in_valid=1 with out_valid=1 -> next cycle out_valid=0. resetn=0 mid-stall -> out_valid=0 immediately.
